riscv_timer: RTL and testbench

Memory-mapped machine timer that sits as a responder on the core's data-memory bus and drives the core's `irq_i` line. It holds a 64-bit free-running `mtime` counter and a 64-bit `mtimecmp` compare register. It raises a level interrupt while `mtime >= mtimecmp` and the interrupt is enabled. Address selection (which requests reach this block) is done by the interconnect; this block responds to every request it receives.

---
 rtl/riscv_timer_if.sv | 19 +
 rtl/riscv_timer.sv | 140 ++++++++++++++
 tb/tb_riscv_timer.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_timer_if.sv
// Bus width constants and the data-memory responder interface for the machine timer.
// Interface only: no logic, so no latency.
// The initiator holds valid_i until ready_o; ready_o is a one-cycle strobe from the responder.
package riscv_timer_pkg;
    localparam int RISCV_ADDR_WIDTH = 32;
    localparam int RISCV_WORD_WIDTH = 32;
endpackage

interface riscv_timer_if;
    logic                                         valid_i;
    logic                                         ready_o;
    logic [riscv_timer_pkg::RISCV_ADDR_WIDTH-1:0] addr_i;
    logic [riscv_timer_pkg::RISCV_WORD_WIDTH-1:0] wdata_i;
    logic [3:0]                                   we_i;
    logic [riscv_timer_pkg::RISCV_WORD_WIDTH-1:0] rdata_o;

    modport master (output valid_i, addr_i, wdata_i, we_i, input  ready_o, rdata_o);
    modport slave  (input  valid_i, addr_i, wdata_i, we_i, output ready_o, rdata_o);
endinterface

// File: rtl/riscv_timer.sv
// Machine timer: 64-bit mtime/mtimecmp with level interrupt; optional prescaler under RISCV_TIMER_PRESCALER_EN.
// Latency: response one cycle after accept; writes visible to an access accepted two cycles later.
// Backpressure: none; a request is accepted in IDLE and valid_i is ignored during the response cycle.
module riscv_timer
    import riscv_timer_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    riscv_timer_if.slave  bus,
    output logic          irq_o
);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RESP = 1'b1;

    logic [0:0]                  r_state;
    logic                        r_ready;
    logic [RISCV_WORD_WIDTH-1:0] r_rdata;
    logic                        r_irq;
    logic [31:0]                 r_mtime_lo;
    logic [31:0]                 r_mtime_hi;
    logic [31:0]                 r_cmp_lo;
    logic [31:0]                 r_cmp_hi;
    logic                        r_en;
    logic                        r_ie;

    logic                        w_accept;
    logic                        w_wr;
    logic [2:0]                  w_off;
    logic                        w_tick;
    logic [63:0]                 w_mtime_inc;
    logic [31:0]                 w_rd_val;

    // Byte-wise merge of write data into an existing register value.
    function automatic logic [31:0] f_merge(input logic [31:0] old_val,
                                            input logic [31:0] new_val,
                                            input logic [3:0]  be);
        logic [31:0] res;
        res = old_val;
        for (int k = 0; k < 4; k++) begin
            if (be[k]) res[8*k +: 8] = new_val[8*k +: 8];
        end
        return res;
    endfunction

    assign w_accept    = (r_state == ST_IDLE) && bus.valid_i;
    assign w_wr        = w_accept && (bus.we_i != 4'b0000);
    assign w_off       = bus.addr_i[4:2];
    assign w_mtime_inc = {r_mtime_hi, r_mtime_lo} + 64'd1;

`ifdef RISCV_TIMER_PRESCALER_EN
    logic [31:0] r_prescale;
    logic [31:0] r_pcnt;

    assign w_tick = r_en && (r_pcnt == r_prescale);

    // Prescale register and divider counter; a PRESCALE write restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prescale <= '0;
            r_pcnt     <= '0;
        end else if (w_wr && w_off == 3'd5) begin
            r_prescale <= f_merge(r_prescale, bus.wdata_i, bus.we_i);
            r_pcnt     <= '0;
        end else if (r_en) begin
            r_pcnt     <= w_tick ? 32'd0 : r_pcnt + 32'd1;
        end
    end
`else
    assign w_tick = r_en;
`endif

    // Read mux over the register map; unmapped offsets read zero.
    always_comb begin
        w_rd_val = '0;
        case (w_off)
            3'd0: w_rd_val = r_mtime_lo;
            3'd1: w_rd_val = r_mtime_hi;
            3'd2: w_rd_val = r_cmp_lo;
            3'd3: w_rd_val = r_cmp_hi;
            3'd4: w_rd_val = {30'd0, r_ie, r_en};
`ifdef RISCV_TIMER_PRESCALER_EN
            3'd5: w_rd_val = r_prescale;
`endif
            default: w_rd_val = '0;
        endcase
    end

    // mtime: a bus write to either half suppresses that cycle's increment entirely.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mtime_lo <= '0;
            r_mtime_hi <= '0;
        end else if (w_wr && (w_off == 3'd0 || w_off == 3'd1)) begin
            if (w_off == 3'd0) r_mtime_lo <= f_merge(r_mtime_lo, bus.wdata_i, bus.we_i);
            if (w_off == 3'd1) r_mtime_hi <= f_merge(r_mtime_hi, bus.wdata_i, bus.we_i);
        end else if (w_tick) begin
            {r_mtime_hi, r_mtime_lo} <= w_mtime_inc;
        end
    end

    // mtimecmp halves and CTRL bits, all byte-merged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmp_lo <= '1;
            r_cmp_hi <= '1;
            r_en     <= 1'b0;
            r_ie     <= 1'b0;
        end else if (w_wr) begin
            if (w_off == 3'd2) r_cmp_lo <= f_merge(r_cmp_lo, bus.wdata_i, bus.we_i);
            if (w_off == 3'd3) r_cmp_hi <= f_merge(r_cmp_hi, bus.wdata_i, bus.we_i);
            if (w_off == 3'd4 && bus.we_i[0]) begin
                r_en <= bus.wdata_i[0];
                r_ie <= bus.wdata_i[1];
            end
        end
    end

    // Two-state handshake: accept in IDLE, strobe ready in RESP, always return to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_state <= w_accept ? ST_RESP : ST_IDLE;
            r_ready <= w_accept;
            r_rdata <= (w_accept && !w_wr) ? w_rd_val : '0;
        end
    end

    // Registered compare so irq_o trails the mtime/mtimecmp relationship by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_irq <= 1'b0;
        else        r_irq <= r_ie && ({r_mtime_hi, r_mtime_lo} >= {r_cmp_hi, r_cmp_lo});
    end

    assign bus.ready_o = r_ready;
    assign bus.rdata_o = r_rdata;
    assign irq_o       = r_irq;
endmodule

// File: tb/tb_riscv_timer.sv
// Bench for riscv_timer: cycle-accurate behavioural model plus directed and random bus traffic.
// Outputs compared every negedge against the model; directed reads pin literal values.
// Requests are held until ready_o, bounded by a cycle budget.
module tb_riscv_timer;
    import riscv_timer_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic irq;
    always #5 clk = ~clk;

    riscv_timer_if bus();
    riscv_timer dut (.clk(clk), .rst_n(rst_n), .bus(bus), .irq_o(irq));

    int checks = 0;
    int errors = 0;
    bit run = 1'b0;

    // Behavioural model state (64-bit arithmetic view of the timer).
    logic [63:0] m_mtime, m_cmp;
    logic        m_en, m_ie, m_resp, m_ready, m_irq;
    logic [31:0] m_rdata;
`ifdef RISCV_TIMER_PRESCALER_EN
    logic [31:0] m_pre, m_pcnt;
`endif

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int k = 0; k < 4; k++) if (be[k]) r[8*k +: 8] = n[8*k +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_read(input logic [2:0] off);
        case (off)
            3'd0: return m_mtime[31:0];
            3'd1: return m_mtime[63:32];
            3'd2: return m_cmp[31:0];
            3'd3: return m_cmp[63:32];
            3'd4: return {30'd0, m_ie, m_en};
`ifdef RISCV_TIMER_PRESCALER_EN
            3'd5: return m_pre;
`endif
            default: return 32'd0;
        endcase
    endfunction

    // Model update: one step per rising edge, reset asynchronously.
    always @(posedge clk or negedge rst_n) begin : model
        logic        acc, wr, tick;
        logic [2:0]  off;
        logic [63:0] nt;
        if (!rst_n) begin
            m_mtime <= 64'd0; m_cmp <= '1; m_en <= 1'b0; m_ie <= 1'b0;
            m_resp <= 1'b0; m_ready <= 1'b0; m_rdata <= 32'd0; m_irq <= 1'b0;
`ifdef RISCV_TIMER_PRESCALER_EN
            m_pre <= 32'd0; m_pcnt <= 32'd0;
`endif
        end else begin
            acc = !m_resp && bus.valid_i;
            off = bus.addr_i[4:2];
            wr  = acc && (bus.we_i != 4'd0);
`ifdef RISCV_TIMER_PRESCALER_EN
            tick = m_en && (m_pcnt == m_pre);
            if (wr && off == 3'd5) begin
                m_pre  <= bmerge(m_pre, bus.wdata_i, bus.we_i);
                m_pcnt <= 32'd0;
            end else if (m_en) begin
                m_pcnt <= tick ? 32'd0 : m_pcnt + 32'd1;
            end
`else
            tick = m_en;
`endif
            m_ready <= acc;
            m_resp  <= acc;
            m_rdata <= (acc && !wr) ? model_read(off) : 32'd0;
            m_irq   <= m_ie && (m_mtime >= m_cmp);
            nt = tick ? m_mtime + 64'd1 : m_mtime;
            if (wr && off == 3'd0) nt = {m_mtime[63:32], bmerge(m_mtime[31:0], bus.wdata_i, bus.we_i)};
            if (wr && off == 3'd1) nt = {bmerge(m_mtime[63:32], bus.wdata_i, bus.we_i), m_mtime[31:0]};
            m_mtime <= nt;
            if (wr && off == 3'd2) m_cmp[31:0]  <= bmerge(m_cmp[31:0], bus.wdata_i, bus.we_i);
            if (wr && off == 3'd3) m_cmp[63:32] <= bmerge(m_cmp[63:32], bus.wdata_i, bus.we_i);
            if (wr && off == 3'd4 && bus.we_i[0]) begin
                m_en <= bus.wdata_i[0];
                m_ie <= bus.wdata_i[1];
            end
        end
    end

    // Per-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (run && rst_n) begin
            check("ready_o", {63'd0, bus.ready_o}, {63'd0, m_ready});
            check("rdata_o", {32'd0, bus.rdata_o}, {32'd0, m_rdata});
            check("irq_o",   {63'd0, irq},         {63'd0, m_irq});
        end
    end

    task automatic access(input logic [2:0] off, input logic [31:0] wd, input logic [3:0] we,
                          output logic [31:0] rd);
        logic [31:0] a;
        bit got;
        got = 1'b0;
        rd  = 32'd0;
        a   = $urandom();
        a[4:2] = off;
        @(negedge clk);
        bus.valid_i = 1'b1;
        bus.addr_i  = a;
        bus.wdata_i = wd;
        bus.we_i    = we;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (bus.ready_o) begin
                got = 1'b1;
                rd  = bus.rdata_o;
            end
        end
        bus.valid_i = 1'b0;
        bus.we_i    = 4'd0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL access_timeout: got no ready_o expected ready_o within 8 cycles at %0t", $time);
        end
    endtask

    task automatic wr(input logic [2:0] off, input logic [31:0] d);
        logic [31:0] dummy;
        access(off, d, 4'hF, dummy);
    endtask

    task automatic rd(input logic [2:0] off, output logic [31:0] d);
        access(off, 32'd0, 4'h0, d);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        logic [31:0] exp_rst [8];
        logic [31:0] exp_pre [5];
        int cnt;
        int cyc;
        exp_rst = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'd0};
        exp_pre = '{32'd0, 32'd0, 32'd1, 32'd1, 32'd2};
        bus.valid_i = 1'b0;
        bus.addr_i  = '0;
        bus.wdata_i = '0;
        bus.we_i    = 4'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        run   = 1'b1;

        // Reset values at every offset.
        check("irq_after_reset", {63'd0, irq}, 64'd0);
        for (int i = 0; i < 8; i++) begin
            rd(3'(i), d);
            check($sformatf("reset_read_off%0d", i), {32'd0, d}, {32'd0, exp_rst[i]});
        end

        // Held valid for four cycles gives exactly two responses.
        cnt = 0;
        @(negedge clk);
        bus.valid_i = 1'b1;
        bus.addr_i  = 32'h0;
        bus.we_i    = 4'd0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.ready_o) cnt++;
        end
        bus.valid_i = 1'b0;
        @(negedge clk);
        if (bus.ready_o) cnt++;
        check("held_valid_responses", 64'(cnt), 64'd2);

        // 64-bit carry through the low-word wrap.
        wr(3'd0, 32'hFFFF_FFFE);
        wr(3'd1, 32'd0);
        wr(3'd4, 32'd1);
        repeat (3) @(negedge clk);
        rd(3'd0, d);
        check("wrap_lo", {32'd0, d}, 64'd2);
        rd(3'd1, d);
        check("wrap_hi", {32'd0, d}, 64'd1);
        wr(3'd4, 32'd0);

        // Byte-enable merge and zero-enable access as a read.
        access(3'd2, 32'hAABB_CCDD, 4'b0101, d);
        check("partial_write_rdata", {32'd0, d}, 64'd0);
        rd(3'd2, d);
        check("byte_enable_merge", {32'd0, d}, 64'hFFBB_FFDD);
        access(3'd2, 32'h1234_5678, 4'b0000, d);
        check("we0_read_value", {32'd0, d}, 64'hFFBB_FFDD);
        rd(3'd2, d);
        check("we0_no_change", {32'd0, d}, 64'hFFBB_FFDD);

        // Interrupt rise, lowering via mtimecmp, and IE masking.
        wr(3'd3, 32'd0);
        wr(3'd2, 32'd20);
        wr(3'd0, 32'd0);
        wr(3'd1, 32'd0);
        wr(3'd4, 32'd3);
        cyc = 0;
        for (int i = 1; i <= 100 && cyc == 0; i++) begin
            @(negedge clk);
            if (irq) cyc = i;
        end
        check("irq_rise_cycles", 64'(cyc), 64'd21);
        wr(3'd3, 32'd1);
        check("irq_still_high_n1", {63'd0, irq}, 64'd1);
        @(negedge clk);
        check("irq_low_n2", {63'd0, irq}, 64'd0);
        wr(3'd4, 32'd1);
        wr(3'd3, 32'd0);
        repeat (3) @(negedge clk);
        check("irq_masked_ie0", {63'd0, irq}, 64'd0);
        wr(3'd4, 32'd0);

`ifdef RISCV_TIMER_PRESCALER_EN
        // Prescale of 3: one increment every four cycles.
        wr(3'd5, 32'd3);
        wr(3'd0, 32'd0);
        wr(3'd1, 32'd0);
        wr(3'd4, 32'd1);
        for (int i = 0; i < 5; i++) begin
            rd(3'd0, d);
            check($sformatf("prescale_read%0d", i), {32'd0, d}, {32'd0, exp_pre[i]});
        end
        rd(3'd5, d);
        check("prescale_reg", {32'd0, d}, 64'd3);
        wr(3'd4, 32'd0);
`else
        // Offset 5 is unmapped without the prescaler.
        wr(3'd5, 32'h1234);
        rd(3'd5, d);
        check("off5_unmapped", {32'd0, d}, 64'd0);
`endif

        // Random traffic against the model.
        for (int n = 0; n < 300; n++) begin
            logic [3:0] we;
            we = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            access(3'($urandom_range(0, 7)), $urandom(), we, d);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Reset asserted during a response cycle with irq high.
        wr(3'd2, 32'd0);
        wr(3'd3, 32'd0);
        wr(3'd4, 32'd3);
        repeat (3) @(negedge clk);
        check("irq_high_before_reset", {63'd0, irq}, 64'd1);
        @(negedge clk);
        bus.valid_i = 1'b1;
        bus.addr_i  = 32'h0;
        bus.we_i    = 4'd0;
        @(posedge clk);
        #1;
        check("ready_before_reset", {63'd0, bus.ready_o}, 64'd1);
        rst_n = 1'b0;
        #1;
        bus.valid_i = 1'b0;
        check("ready_in_reset", {63'd0, bus.ready_o}, 64'd0);
        check("rdata_in_reset", {32'd0, bus.rdata_o}, 64'd0);
        check("irq_in_reset",   {63'd0, irq}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rd(3'd3, d);
        check("cmp_hi_after_reset", {32'd0, d}, 64'hFFFF_FFFF);
        rd(3'd4, d);
        check("ctrl_after_reset", {32'd0, d}, 64'd0);
        rd(3'd0, d);
        check("mtime_lo_after_reset", {32'd0, d}, 64'd0);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
